// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator error monitor.
// Holds the controller state encoding, the LFSR tap mask and the operand width default.
package cmp_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} cmp_state_e;

   localparam logic [31:0] LfsrMask     = 32'h8020_0003;
   localparam int unsigned WidthDefault = 16;

   // One right-shifting Galois step for x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LfsrMask : 32'h0);
   endfunction

endpackage

// File: rtl/cmp_vec_gen.sv
// 32-bit test vector generator: Galois LFSR or incrementing sweep.
// The mode is captured on load; the value register itself feeds the operand outputs.
module cmp_vec_gen
   import cmp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   input  logic        mode,
   input  logic [31:0] seed,
   output logic [31:0] value
);

   logic        mode_q;
   logic [31:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         // The all-zero state locks up the LFSR, so it is replaced by 1.
         value_d = (!mode && seed == 32'h0) ? 32'h1 : seed;
      end else if (advance) begin
         value_d = mode_q ? value_q + 32'd1 : lfsr_step(value_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= 1'b0;
         value_q <= 32'h0;
      end else begin
         value_q <= value_d;
         if (load) mode_q <= mode;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/cmp_error_monitor.sv
// Drives vectors into an external comparator and counts flag mismatches against an exact
// reference compare whose result is delayed RESP_LAT cycles to line up with the responses.
module cmp_error_monitor
   import cmp_pkg::*;
#(
   parameter int unsigned RESP_LAT = 1,
   parameter int unsigned WIDTH    = WidthDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_mode,
   input  logic [31:0]      seed,
   input  logic [15:0]      num_vec,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   input  logic             dut_eq,
   input  logic             dut_gt,
   input  logic             dut_lt,
   output logic             busy,
   output logic             done,
   output logic [15:0]      err_count,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b,
   output logic             first_err_valid
);

   cmp_state_e  state_q, state_d;
   logic [16:0] vec_left_q, vec_left_d;
   logic [2:0]  drain_q, drain_d;
   logic        gen_load, gen_adv, accept;
   logic [31:0] gen_value;

   cmp_vec_gen u_vec_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (gen_load),
      .advance (gen_adv),
      .mode    (vec_mode),
      .seed    (seed),
      .value   (gen_value)
   );

   assign accept = (state_q == StIdle) && start;

   always_comb begin
      state_d    = state_q;
      vec_left_d = vec_left_q;
      drain_d    = drain_q;
      gen_load   = 1'b0;
      gen_adv    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StRun;
               gen_load   = 1'b1;
               vec_left_d = (num_vec == 16'h0) ? 17'h1_0000 : {1'b0, num_vec};
            end
         end
         StRun: begin
            // The last vector is not followed by an advance so the operands hold it.
            if (vec_left_q == 17'd1) begin
               state_d = StDrain;
               drain_d = 3'd0;
            end else begin
               vec_left_d = vec_left_q - 17'd1;
               gen_adv    = 1'b1;
            end
         end
         StDrain: begin
            if (drain_q == 3'(RESP_LAT - 1)) state_d = StDone;
            else drain_d = drain_q + 3'd1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         vec_left_q <= 17'h0;
         drain_q    <= 3'h0;
      end else begin
         state_q    <= state_d;
         vec_left_q <= vec_left_d;
         drain_q    <= drain_d;
      end
   end

   assign op_a     = gen_value[2*WIDTH-1:WIDTH];
   assign op_b     = gen_value[WIDTH-1:0];
   assign op_valid = (state_q == StRun);
   assign busy     = (state_q == StRun) || (state_q == StDrain);
   assign done     = (state_q == StDone);

   // Reference flags travel alongside their operands until the response arrives.
   logic [2:0]       exp_flags;
   logic [RESP_LAT-1:0] pipe_valid_q;
   logic [2:0]       pipe_flags_q [RESP_LAT];
   logic [WIDTH-1:0] pipe_a_q     [RESP_LAT];
   logic [WIDTH-1:0] pipe_b_q     [RESP_LAT];

   assign exp_flags = {op_a == op_b, op_a > op_b, op_a < op_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid_q <= '0;
         for (int i = 0; i < int'(RESP_LAT); i++) begin
            pipe_flags_q[i] <= 3'h0;
            pipe_a_q[i]     <= '0;
            pipe_b_q[i]     <= '0;
         end
      end else begin
         pipe_valid_q[0] <= op_valid;
         pipe_flags_q[0] <= exp_flags;
         pipe_a_q[0]     <= op_a;
         pipe_b_q[0]     <= op_b;
         for (int i = 1; i < int'(RESP_LAT); i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_flags_q[i] <= pipe_flags_q[i-1];
            pipe_a_q[i]     <= pipe_a_q[i-1];
            pipe_b_q[i]     <= pipe_b_q[i-1];
         end
      end
   end

   logic mismatch;
   assign mismatch = pipe_valid_q[RESP_LAT-1] &&
                     ({dut_eq, dut_gt, dut_lt} != pipe_flags_q[RESP_LAT-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count       <= 16'h0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         first_err_valid <= 1'b0;
      end else if (accept) begin
         err_count       <= 16'h0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         first_err_valid <= 1'b0;
      end else if (mismatch) begin
         if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         if (!first_err_valid) begin
            first_err_a     <= pipe_a_q[RESP_LAT-1];
            first_err_b     <= pipe_b_q[RESP_LAT-1];
            first_err_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmp_error_monitor.sv
// Randomized self-checking bench: emulates a faulty comparator with response latency and
// checks vectors, timing and error results against a behavioural model.
module tb_cmp_error_monitor;

   localparam int unsigned RespLat = 2;

   logic        clk = 1'b0;
   logic        rst_n, start, vec_mode;
   logic [31:0] seed;
   logic [15:0] num_vec;
   logic [15:0] op_a, op_b, err_count, first_err_a, first_err_b;
   logic        op_valid, busy, done, first_err_valid;
   logic        dut_eq, dut_gt, dut_lt;

   int total_cnt = 0;
   int bad_cnt   = 0;

   cmp_error_monitor #(
      .RESP_LAT (RespLat),
      .WIDTH    (16)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .vec_mode        (vec_mode),
      .seed            (seed),
      .num_vec         (num_vec),
      .op_a            (op_a),
      .op_b            (op_b),
      .op_valid        (op_valid),
      .dut_eq          (dut_eq),
      .dut_gt          (dut_gt),
      .dut_lt          (dut_lt),
      .busy            (busy),
      .done            (done),
      .err_count       (err_count),
      .first_err_a     (first_err_a),
      .first_err_b     (first_err_b),
      .first_err_valid (first_err_valid)
   );

   always #5 clk = ~clk;

   // Emulated comparator under test: flags chosen per vector, returned RespLat cycles later.
   logic [2:0] cur_f = 3'h0;
   logic [2:0] hf [RespLat];

   always @(posedge clk) begin
      hf[0] <= cur_f;
      for (int i = 1; i < int'(RespLat); i++) hf[i] <= hf[i-1];
   end

   assign {dut_eq, dut_gt, dut_lt} = hf[RespLat-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // cm: 0 exact, 1 eq stuck at 0, 2 all flags inverted, 3 random corruption.
   task automatic do_run(input logic mode, input logic [31:0] sd, input logic [15:0] nv,
                         input int cm, input bit poke);
      int          total, nvalid, nbad_vec, cyc, last_v, done_cyc, ndone, errs;
      logic [31:0] g;
      logic [15:0] a, b, fa, fb;
      logic [2:0]  ex, cf;
      bit          fvalid, fin;
      total = (nv == 0) ? 65536 : int'(nv);
      g = (!mode && sd == 32'h0) ? 32'h1 : sd;
      nvalid = 0; nbad_vec = 0; cyc = 0; last_v = 0; done_cyc = -100; ndone = 0; errs = 0;
      fvalid = 0; fin = 0; fa = 0; fb = 0;
      @(negedge clk);
      vec_mode = mode; seed = sd; num_vec = nv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_after_start", busy, 1);
      check_eq("first_vector", {op_a, op_b}, g);
      while (!fin && cyc < total + int'(RespLat) + 20) begin
         start = 1'b0;
         if (op_valid) begin
            a = g[31:16];
            b = g[15:0];
            if ({op_a, op_b} !== g) nbad_vec++;
            ex = {a == b, a > b, a < b};
            case (cm)
               1:       cf = {1'b0, ex[1:0]};
               2:       cf = ~ex;
               3:       cf = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ex;
               default: cf = ex;
            endcase
            if (cf != ex) begin
               errs++;
               if (!fvalid) begin
                  fvalid = 1; fa = a; fb = b;
               end
            end
            cur_f = cf;
            if (mode) g = g + 32'd1;
            else g = (g >> 1) ^ (g[0] ? 32'h8020_0003 : 32'h0);
            last_v = cyc;
            nvalid++;
            if (poke && nvalid == 2) start = 1'b1;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            check_eq("busy_low_at_done", busy, 0);
            fin = 1;
            if (poke) start = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq("timeout", fin, 1);
      check_eq("done_single_pulse", done, 0);
      check_eq("busy_after_done", busy, 0);
      check_eq("op_valid_count", nvalid, total);
      check_eq("vector_mismatches", nbad_vec, 0);
      check_eq("done_latency", done_cyc - last_v, RespLat + 1);
      check_eq("err_count", err_count, (errs > 65535) ? 65535 : errs);
      check_eq("first_err_valid", first_err_valid, fvalid);
      if (fvalid) begin
         check_eq("first_err_a", first_err_a, fa);
         check_eq("first_err_b", first_err_b, fb);
      end
      @(negedge clk);
      check_eq("idle_stays_idle", busy, 0);
      check_eq("err_count_held", err_count, (errs > 65535) ? 65535 : errs);
   endtask

   task automatic reset_mid_run();
      int nvalid, ndone;
      nvalid = 0; ndone = 0;
      @(negedge clk);
      vec_mode = 1'b1; seed = 32'h0000_0100; num_vec = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && nvalid < 10; i++) begin
         if (op_valid) begin
            nvalid++;
            cur_f = ~{op_a == op_b, op_a > op_b, op_a < op_b};
         end
         if (nvalid < 10) @(negedge clk);
      end
      check_eq("err_before_reset_nonzero", err_count != 16'h0, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_op_valid", op_valid, 0);
      check_eq("rst_ops", {op_a, op_b}, 0);
      check_eq("rst_err_count", err_count, 0);
      check_eq("rst_first_err", {first_err_valid, first_err_a, first_err_b}, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_eq("no_done_after_abort", ndone, 0);
      check_eq("idle_after_abort", busy, 0);
      do_run(1'b1, 32'h0007_0007, 16'd2, 2, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; vec_mode = 1'b0; seed = 32'h0; num_vec = 16'h0;
      repeat (2) @(negedge clk);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_op_valid", op_valid, 0);
      check_eq("reset_ops", {op_a, op_b}, 0);
      check_eq("reset_err", {first_err_valid, err_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_run(1'b0, 32'h1234_5678, 16'd1000, 0, 1'b0);
      do_run(1'b1, 32'h0005_0004, 16'd3, 1, 1'b0);
      check_eq("sweep_first_err", {first_err_a, first_err_b}, 32'h0005_0005);
      check_eq("sweep_err_one", err_count, 1);
      reset_mid_run();
      do_run(1'b1, 32'hFFFF_FFFF, 16'd2, 0, 1'b0);
      check_eq("wrap_last_vector", {op_a, op_b}, 32'h0);
      do_run(1'b0, 32'h0, 16'd3, 3, 1'b1);
      for (int k = 0; k < 6; k++) begin
         do_run(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(1, 40)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      do_run(1'b0, 32'hCAFE_1234, 16'd0, 2, 1'b0);
      check_eq("saturated_first_err", {first_err_a, first_err_b}, 32'hCAFE_1234);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
